iter_divider: RTL and testbench

Parametrised iterative radix-4 integer divider for the execute stage, successor to the fixed 32-bit unit. Computes quotient and remainder of signed or unsigned WIDTH-bit operands with leading-zero early-out, defined divide-by-zero results, pipeline flush and a tag passthrough. Both sides use valid/ready handshakes. One operation is in flight at a time.

---
 rtl/divider_pkg.sv | 21 ++
 rtl/div_lzc.sv | 36 +++
 rtl/iter_divider.sv | 193 +++++++++++++++++++
 tb/tb_iter_divider.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative radix-4 divider.
// Contents: FSM state enum, step-count helper, divide-by-zero quotient bit.
package divider_pkg;

    // Controller states: waiting, iterating, holding a result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Quotient for a zero divisor is all ones; replicate this bit to the operand width.
    localparam logic DBZ_Q_BIT = 1'b1;

    // Radix-4 steps still needed once the leading zero bit-pairs are skipped.
    function automatic int unsigned step_count(input int unsigned width,
                                               input int unsigned lzp);
        return (width / 2) - lzp;
    endfunction

endpackage

// File: rtl/div_lzc.sv
// Leading-zero bit-pair counter, purely combinational.
// Ports:
//   i_val  : value to scan (WIDTH bits, scanned from the MSB pair downwards)
//   o_lzp  : number of all-zero bit-pairs above the first non-zero pair
//            (WIDTH/2 when i_val is zero)
module div_lzc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]          i_val,
    output logic [$clog2(WIDTH/2):0]  o_lzp
);

    localparam int unsigned NPAIR = WIDTH / 2;
    localparam int unsigned CNT_W = $clog2(WIDTH/2) + 1;

    logic             w_found;
    logic [CNT_W-1:0] w_cnt;

    // Count zero pairs until the first non-zero pair is met.
    always_comb begin
        w_found = 1'b0;
        w_cnt   = '0;
        for (int i = NPAIR - 1; i >= 0; i--) begin
            if (!w_found) begin
                if (|i_val[2*i +: 2]) begin
                    w_found = 1'b1;
                end else begin
                    w_cnt = w_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_lzp = w_cnt;

endmodule

// File: rtl/iter_divider.sv
// Iterative radix-4 signed/unsigned integer divider with leading-zero early-out,
// defined divide-by-zero results, flush and tag passthrough.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush_i             : synchronous kill of any operation in flight
//   div_valid_i/ready_o : request handshake (div_signed_i, div_tag_i, Z_i, D_i)
//   res_valid_o/ready_i : result handshake (q_o, s_o, tag_o)
//   busy_o              : controller not idle
module iter_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned EARLY_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    input  logic             div_signed_i,
    input  logic [TAG_W-1:0] div_tag_i,
    input  logic [WIDTH-1:0] Z_i,
    input  logic [WIDTH-1:0] D_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] s_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH/2) + 1;
    localparam int unsigned EXT_W = WIDTH + 3;

    // Controller and datapath registers.
    div_state_e       r_state;
    logic [WIDTH-1:0] r_z;      // remaining dividend bits on top, quotient digits shifted in below
    logic [WIDTH-1:0] r_rem;    // partial remainder, always < |D|
    logic [WIDTH-1:0] r_absd;
    logic             r_negq;
    logic             r_negr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_s;
    logic [TAG_W-1:0] r_tag;

    // Request-side operand conditioning.
    logic             w_accept;
    logic             w_negz_in;
    logic             w_negd_in;
    logic [WIDTH-1:0] w_absz;
    logic [WIDTH-1:0] w_absd;
    logic [CNT_W-1:0] w_lzp_raw;
    logic [CNT_W-1:0] w_lzp;
    logic [WIDTH-1:0] w_z_pre;
    logic [CNT_W-1:0] w_steps;

    assign div_ready_o = ~flush_i & ((r_state == ST_IDLE) |
                                     ((r_state == ST_DONE) & res_ready_i));
    assign w_accept    = div_valid_i & div_ready_o;

    assign w_negz_in = div_signed_i & Z_i[WIDTH-1];
    assign w_negd_in = div_signed_i & D_i[WIDTH-1];
    assign w_absz    = w_negz_in ? (~Z_i + WIDTH'(1)) : Z_i;
    assign w_absd    = w_negd_in ? (~D_i + WIDTH'(1)) : D_i;

    div_lzc #(
        .WIDTH (WIDTH)
    ) u_lzc (
        .i_val (w_absz),
        .o_lzp (w_lzp_raw)
    );

    assign w_lzp   = (EARLY_OUT != 0) ? w_lzp_raw : '0;
    // Leading zero pairs are shifted out so the first step sees a non-zero pair.
    assign w_z_pre = w_absz << {w_lzp, 1'b0};
    assign w_steps = CNT_W'(step_count(WIDTH, 32'(w_lzp)));

    // One radix-4 step: compare the shifted remainder against 3|D|, 2|D|, |D|.
    logic [WIDTH+1:0] w_cand;
    logic [EXT_W-1:0] w_cand_x;
    logic [EXT_W-1:0] w_d1;
    logic [EXT_W-1:0] w_d2;
    logic [EXT_W-1:0] w_d3;
    logic [EXT_W-1:0] w_s1;
    logic [EXT_W-1:0] w_s2;
    logic [EXT_W-1:0] w_s3;
    logic [1:0]       w_digit;
    logic [WIDTH-1:0] w_remnext;
    logic [WIDTH-1:0] w_qnext;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_s_fin;
    logic             w_unused_hi;

    assign w_cand   = {r_rem, r_z[WIDTH-1 -: 2]};
    assign w_cand_x = {1'b0, w_cand};
    assign w_d1     = {3'b000, r_absd};
    assign w_d2     = {2'b00, r_absd, 1'b0};
    assign w_d3     = w_d1 + w_d2;
    assign w_s1     = w_cand_x - w_d1;
    assign w_s2     = w_cand_x - w_d2;
    assign w_s3     = w_cand_x - w_d3;

    // Candidate < 4|D|, so any non-negative difference is < |D| and fits WIDTH bits.
    assign w_unused_hi = ^{w_s1[WIDTH+1:WIDTH], w_s2[WIDTH+1:WIDTH], w_s3[WIDTH+1:WIDTH]};

    // Take the largest non-negative difference.
    always_comb begin
        w_digit   = 2'd0;
        w_remnext = w_cand[WIDTH-1:0];
        if (!w_s3[EXT_W-1]) begin
            w_digit   = 2'd3;
            w_remnext = w_s3[WIDTH-1:0];
        end else if (!w_s2[EXT_W-1]) begin
            w_digit   = 2'd2;
            w_remnext = w_s2[WIDTH-1:0];
        end else if (!w_s1[EXT_W-1]) begin
            w_digit   = 2'd1;
            w_remnext = w_s1[WIDTH-1:0];
        end
    end

    assign w_qnext = {r_z[WIDTH-3:0], w_digit};
    assign w_q_fin = r_negq ? (~w_qnext + WIDTH'(1)) : w_qnext;
    assign w_s_fin = r_negr ? (~w_remnext + WIDTH'(1)) : w_remnext;

    // Controller and datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_z     <= '0;
            r_rem   <= '0;
            r_absd  <= '0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_s     <= '0;
            r_tag   <= '0;
        end else if (flush_i) begin
            r_state <= ST_IDLE;
        end else if (w_accept) begin
            r_tag <= div_tag_i;
            if (D_i == '0) begin
                r_q     <= {WIDTH{DBZ_Q_BIT}};
                r_s     <= Z_i;
                r_state <= ST_DONE;
            end else if (w_absz == '0) begin
                r_q     <= '0;
                r_s     <= '0;
                r_state <= ST_DONE;
            end else begin
                r_z     <= w_z_pre;
                r_rem   <= '0;
                r_absd  <= w_absd;
                r_negq  <= w_negz_in ^ w_negd_in;
                r_negr  <= w_negz_in;
                r_cnt   <= w_steps;
                r_state <= ST_CALC;
            end
        end else begin
            case (r_state)
                ST_CALC: begin
                    r_z   <= w_qnext;
                    r_rem <= w_remnext;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last step: apply sign correction on the way into DONE.
                    if (r_cnt == CNT_W'(1)) begin
                        r_q     <= w_q_fin;
                        r_s     <= w_s_fin;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid_o = (r_state == ST_DONE) & ~flush_i;
    assign busy_o      = (r_state != ST_IDLE);
    assign q_o         = r_q;
    assign s_o         = r_s;
    assign tag_o       = r_tag;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider (WIDTH=32, TAG_W=4, EARLY_OUT=1).
module tb_iter_divider;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          div_valid_i;
    logic          div_ready_o;
    logic          div_signed_i;
    logic [TW-1:0] div_tag_i;
    logic [W-1:0]  Z_i;
    logic [W-1:0]  D_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [W-1:0]  q_o;
    logic [W-1:0]  s_o;
    logic [TW-1:0] tag_o;
    logic          busy_o;

    iter_divider #(
        .WIDTH     (W),
        .TAG_W     (TW),
        .EARLY_OUT (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .div_valid_i  (div_valid_i),
        .div_ready_o  (div_ready_o),
        .div_signed_i (div_signed_i),
        .div_tag_i    (div_tag_i),
        .Z_i          (Z_i),
        .D_i          (D_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .q_o          (q_o),
        .s_o          (s_o),
        .tag_o        (tag_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference quotient/remainder: {q, s}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] z,
                                            input logic [31:0] d);
        longint zs, ds, qq, rr;
        logic [31:0] q32, r32;
        if (d == 32'd0) return {32'hFFFF_FFFF, z};
        if (sgn) begin
            zs = longint'($signed(z));
            ds = longint'($signed(d));
        end else begin
            zs = longint'({32'd0, z});
            ds = longint'({32'd0, d});
        end
        qq  = zs / ds;
        rr  = zs % ds;
        q32 = qq[31:0];
        r32 = rr[31:0];
        return {q32, r32};
    endfunction

    // Expected latency: number of significant bit-pairs of |Z|, 0 for bypass.
    function automatic int ref_lat(input logic sgn, input logic [31:0] z, input logic [31:0] d);
        logic [31:0] a;
        int bl;
        if (d == 32'd0) return 0;
        a = (sgn && z[31]) ? (32'd0 - z) : z;
        if (a == 32'd0) return 0;
        bl = 0;
        for (int i = 0; i < 32; i++) if (a[i]) bl = i + 1;
        return (bl + 1) / 2;
    endfunction

    // Issue one request, wait for the result, check it, optionally stall, then retire it.
    task automatic do_op(input logic sgn, input logic [31:0] z, input logic [31:0] d,
                         input logic [3:0] tag, input logic [31:0] eq, input logic [31:0] es,
                         input int elat, input int stall, input string nm);
        int  k;
        bit  seen;
        bit  stable;
        @(negedge clk);
        div_signed_i = sgn; Z_i = z; D_i = d; div_tag_i = tag;
        div_valid_i  = 1'b1; res_ready_i = 1'b0;
        chk({nm, " req ready"}, div_ready_o, 1);
        @(posedge clk); #1;
        div_valid_i  = 1'b0;
        Z_i = $urandom; D_i = $urandom; div_signed_i = ~sgn; div_tag_i = ~tag;
        seen = 1'b0; k = 0;
        while (!seen && k <= 40) begin
            @(negedge clk);
            if (res_valid_o) seen = 1'b1;
            else k++;
        end
        chk({nm, " valid seen"}, seen, 1);
        if (seen) begin
            if (elat >= 0) chk({nm, " latency"}, k, elat);
            chk({nm, " q"}, q_o, eq);
            chk({nm, " s"}, s_o, es);
            chk({nm, " tag"}, tag_o, tag);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                stable = res_valid_o && !div_ready_o && (q_o == eq) && (s_o == es) && (tag_o == tag);
                chk({nm, " hold"}, stable, 1);
            end
        end
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        @(negedge clk);
        chk({nm, " idle after"}, {busy_o, res_valid_o}, 2'b00);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] z;
        logic [31:0] d;
        logic [31:0] q;
        logic [31:0] s;
        int          lat;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  k;
        bit  seen;
        bit  bad;
        logic [63:0] r;
        logic        sg;
        logic [31:0] z, d;

        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; flush_i = 1'b0; div_valid_i = 1'b0; div_signed_i = 1'b0;
        div_tag_i = '0; Z_i = '0; D_i = '0; res_ready_i = 1'b0;

        //            sgn   Z               D               q               s               lat
        vt[0]  = '{1'b0, 32'd100,         32'd7,          32'd14,         32'd2,          4};
        vt[1]  = '{1'b1, 32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  2};
        vt[2]  = '{1'b1, 32'd7,           32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          2};
        vt[3]  = '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          16};
        vt[4]  = '{1'b0, 32'h0000_1234,   32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  0};
        vt[5]  = '{1'b1, 32'h0000_1234,   32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  0};
        vt[6]  = '{1'b0, 32'd0,           32'd5,          32'd0,          32'd0,          0};
        vt[7]  = '{1'b0, 32'd1,           32'd1,          32'd1,          32'd0,          1};
        vt[8]  = '{1'b0, 32'hFFFF_FFFF,   32'd1,          32'hFFFF_FFFF,  32'd0,          16};
        vt[9]  = '{1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,  32'd1,          32'd0,          16};
        vt[10] = '{1'b0, 32'h8000_0000,   32'd3,          32'h2AAA_AAAA,  32'd2,          16};
        vt[11] = '{1'b1, 32'hFFFF_FF9C,   32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  4};
        vt[12] = '{1'b1, 32'hFFFF_FFF8,   32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  2};
        vt[13] = '{1'b0, 32'd1000000,     32'd1000,       32'd1000,       32'd0,          10};
        vt[14] = '{1'b1, 32'hFFFF_FFF0,   32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0,  0};
        vt[15] = '{1'b1, 32'h7FFF_FFFF,   32'hFFFF_FFFF,  32'h8000_0001,  32'd0,          16};
        vt[16] = '{1'b0, 32'd12345678,    32'd7,          32'd1763668,    32'd2,          12};
        vt[17] = '{1'b1, 32'd0,           32'hFFFF_FFFD,  32'd0,          32'd0,          0};
        vt[18] = '{1'b0, 32'd5,           32'd9,          32'd0,          32'd5,          2};

        // Reset state.
        #3;
        chk("reset res_valid", res_valid_o, 0);
        chk("reset div_ready", div_ready_o, 1);
        chk("reset busy", busy_o, 0);
        chk("reset q", q_o, 0);
        chk("reset s", s_o, 0);
        chk("reset tag", tag_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            do_op(vt[i].sgn, vt[i].z, vt[i].d, 4'(i), vt[i].q, vt[i].s, vt[i].lat,
                  i % 3, $sformatf("vec%0d", i));
        end

        // Back-pressure then back-to-back accept in the result-transfer cycle.
        @(negedge clk);
        div_signed_i = 1'b0; Z_i = 32'd100; D_i = 32'd7; div_tag_i = 4'd3; div_valid_i = 1'b1;
        @(posedge clk); #1; div_valid_i = 1'b0; Z_i = '0; D_i = '0;
        seen = 1'b0; k = 0;
        while (!seen && k <= 40) begin
            @(negedge clk);
            if (res_valid_o) seen = 1'b1; else k++;
        end
        chk("b2b first valid", seen, 1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!(res_valid_o && !div_ready_o && q_o == 32'd14 && s_o == 32'd2 && tag_o == 4'd3)) bad = 1'b1;
            @(negedge clk);
        end
        chk("b2b stall hold", bad, 0);
        res_ready_i = 1'b1; div_valid_i = 1'b1;
        div_signed_i = 1'b1; Z_i = 32'hFFFF_FFF9; D_i = 32'd2; div_tag_i = 4'd9;
        #1;
        chk("b2b both handshakes", {res_valid_o, div_ready_o}, 2'b11);
        @(posedge clk); #1;
        div_valid_i = 1'b0; res_ready_i = 1'b0; Z_i = $urandom; D_i = $urandom;
        seen = 1'b0; k = 0;
        while (!seen && k <= 40) begin
            @(negedge clk);
            if (res_valid_o) seen = 1'b1; else k++;
        end
        chk("b2b second valid", seen, 1);
        chk("b2b second latency", k, 2);
        chk("b2b second q", q_o, 32'hFFFF_FFFD);
        chk("b2b second s", s_o, 32'hFFFF_FFFF);
        chk("b2b second tag", tag_o, 4'd9);
        res_ready_i = 1'b1; @(posedge clk); #1; res_ready_i = 1'b0;

        // Flush three cycles into a 16-step division, with a competing request.
        @(negedge clk);
        div_signed_i = 1'b0; Z_i = 32'hFFFF_FFFF; D_i = 32'd1; div_tag_i = 4'd5; div_valid_i = 1'b1;
        @(posedge clk); #1; div_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        flush_i = 1'b1; div_valid_i = 1'b1; Z_i = 32'd50; D_i = 32'd3;
        #1;
        chk("flush calc masks", {res_valid_o, div_ready_o}, 2'b00);
        @(posedge clk); #1; flush_i = 1'b0; div_valid_i = 1'b0;
        @(negedge clk);
        chk("flush calc busy", busy_o, 0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid_o || busy_o) bad = 1'b1;
        end
        chk("flush calc no result", bad, 0);
        do_op(1'b0, 32'd100, 32'd7, 4'd4, 32'd14, 32'd2, 4, 0, "post flush");

        // Flush while a result is held.
        @(negedge clk);
        div_signed_i = 1'b0; Z_i = 32'd100; D_i = 32'd7; div_tag_i = 4'd6; div_valid_i = 1'b1;
        @(posedge clk); #1; div_valid_i = 1'b0;
        seen = 1'b0; k = 0;
        while (!seen && k <= 40) begin
            @(negedge clk);
            if (res_valid_o) seen = 1'b1; else k++;
        end
        chk("flush done valid", seen, 1);
        res_ready_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush done masks", {res_valid_o, div_ready_o}, 2'b00);
        @(posedge clk); #1; flush_i = 1'b0; res_ready_i = 1'b0;
        @(negedge clk);
        chk("flush done idle", {busy_o, res_valid_o}, 2'b00);

        // Asynchronous reset in the middle of a long division.
        @(negedge clk);
        div_signed_i = 1'b0; Z_i = 32'hFFFF_FFFF; D_i = 32'd3; div_tag_i = 4'd7; div_valid_i = 1'b1;
        @(posedge clk); #1; div_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #2; rst_n = 1'b0;
        #1;
        chk("async reset outputs", {res_valid_o, div_ready_o, busy_o}, 3'b010);
        chk("async reset q", q_o, 0);
        chk("async reset s", s_o, 0);
        chk("async reset tag", tag_o, 0);
        @(negedge clk); rst_n = 1'b1;
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 4'd8, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 4, 1, "post reset");

        // Random operands against the reference model.
        for (int i = 0; i < 300; i++) begin
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       z = $urandom;
                1:       z = 32'($urandom_range(0, 300));
                2:       z = $urandom >> $urandom_range(0, 31);
                default: z = 32'h8000_0000;
            endcase
            case ($urandom_range(0, 5))
                0:       d = 32'd0;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'($urandom_range(1, 20));
                3:       d = $urandom >> $urandom_range(0, 31);
                default: d = $urandom;
            endcase
            r = ref_div(sg, z, d);
            do_op(sg, z, d, 4'($urandom_range(0, 15)), r[63:32], r[31:0],
                  ref_lat(sg, z, d), $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
